// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Types and constants shared by the fetch stage and the decode /
// immediate-generator stage.
//   fetch_state_e : fetch FSM states
//   NOP_INSTR     : canonical NOP (addi x0,x0,0) used when the output slot is empty
//   OPC_*         : RV32I major opcodes (instr[6:0])
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register with a +4 incrementer and a redirect mux.
// Redirect targets have their low two bits masked so the PC stays word aligned.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   redirect     : load redirect_pc (has priority over advance)
//   redirect_pc  : new target (bits[1:0] ignored)
//   advance      : step to pc+4 (wraps modulo 2^32)
//   pc           : current fetch address
// ---------------------------------------------------------------------------
module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC & ~32'h3;
        end else if (redirect) begin
            pc <= redirect_pc & ~32'h3;
        end else if (advance) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage: owns the PC, keeps at most one request outstanding to
// instruction memory and holds the fetched word in an output register with a
// valid/ready handshake towards decode. Redirects squash wrong-path fetches.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect with redirect_pc[1:0] != 0 parks the unit in FAULT
//               until an aligned redirect or reset
//   undefined : low target bits are masked, fetch_misaligned is tied 0
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   imem_req/addr      : fetch request and word-aligned address
//   imem_gnt           : request accepted
//   imem_rvalid/rdata  : response data
//   redirect_valid/pc  : single-cycle branch/jump redirect
//   instr_valid/ready  : output handshake to decode
//   instr, instr_pc    : fetched instruction and its address
//   fetch_misaligned   : unit is in FAULT (misaligned redirect)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | first cycle after reset
// REQ   | request at pc, asserted only while the output slot is free
// WAIT  | granted, waiting for rvalid (drop=1 discards the response)
// FAULT | misaligned redirect seen; no fetching until aligned redirect
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misaligned
);

    fetch_state_e state;
    logic         drop;
    logic [31:0]  pc;
    logic         grant;
    logic         advance;

    // Request only when the output register can take the response.
    assign imem_req  = (state == REQ) && (!instr_valid || instr_ready);
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;
    assign advance   = (state == WAIT) && imem_rvalid && !drop;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign fetch_misaligned = (state == FAULT);
`else
    assign fetch_misaligned = 1'b0;
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect_valid),
        .redirect_pc (redirect_pc),
        .advance     (advance),
        .pc          (pc)
    );

    // rvalid is only honoured in WAIT (and absorbed in FAULT), so a response
    // to a request issued before reset lands in IDLE/REQ and is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= 32'h0;
            drop        <= 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end

            if (redirect_valid) begin
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
                case (state)
                    REQ: begin
                        if (grant) begin
                            drop  <= 1'b1;
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        // Response arriving with the redirect is wrong-path
                        // but closes the transaction, so nothing to drop later.
                        if (imem_rvalid) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end
                    FAULT: begin
                        // A request still outstanding from before the fault
                        // must be drained before fetching again.
                        if (imem_rvalid || !drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    default: state <= REQ;
                endcase
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirect_pc[1:0] != 2'b00) begin
                    state <= FAULT;
                end
`endif
            end else begin
                case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        if (grant) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            if (!drop) begin
                                instr       <= imem_rdata;
                                instr_pc    <= pc;
                                instr_valid <= 1'b1;
                            end
                            drop  <= 1'b0;
                            state <= REQ;
                        end
                    end
                    FAULT: begin
                        if (imem_rvalid) begin
                            drop <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misaligned;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Instruction memory model: grants whenever mem_auto, answers mem_lat
    // cycles after the grant with a word derived from the address.
    logic        mem_auto = 1'b1;
    int          mem_lat  = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a + 32'h0100_0013;
    endfunction

    assign imem_gnt    = mem_auto && imem_req;
    assign imem_rvalid = (pend_cnt == 1);
    assign imem_rdata  = imem_rvalid ? word_of(pend_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            pend_addr <= imem_addr;
            pend_cnt  <= mem_lat;
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;

        repeat (2) cyc();
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_misal", {31'b0, fetch_misaligned}, 32'd0);
        reset = 1'b0;

        // Zero-wait streaming: 0, 4, 8
        cyc();                                                   // E1
        chk("e1_req", {31'b0, imem_req}, 32'd1);
        chk("e1_addr", imem_addr, 32'h0);
        cyc();                                                   // E2
        chk("e2_req", {31'b0, imem_req}, 32'd0);
        chk("e2_valid", {31'b0, instr_valid}, 32'd0);
        cyc();                                                   // E3
        chk("e3_valid", {31'b0, instr_valid}, 32'd1);
        chk("e3_pc", instr_pc, 32'h0);
        chk("e3_instr", instr, word_of(32'h0));
        chk("e3_addr", imem_addr, 32'h4);
        cyc();                                                   // E4
        chk("e4_valid", {31'b0, instr_valid}, 32'd0);
        cyc();                                                   // E5
        chk("e5_valid", {31'b0, instr_valid}, 32'd1);
        chk("e5_pc", instr_pc, 32'h4);
        cyc();                                                   // E6
        chk("e6_valid", {31'b0, instr_valid}, 32'd0);
        cyc();                                                   // E7
        chk("e7_pc", instr_pc, 32'h8);
        chk("e7_instr", instr, word_of(32'h8));

        // Back-pressure for 5 cycles
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();                                               // E8..E12
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_instr", instr, word_of(32'h8));
        end
        instr_ready = 1'b1;
        #1;
        chk("resume_req", {31'b0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'hC);
        cyc();                                                   // E13
        cyc();                                                   // E14
        chk("resume_pc", instr_pc, 32'hC);
        chk("resume_valid", {31'b0, instr_valid}, 32'd1);

        // Redirect while waiting on a slow response
        mem_lat = 3;
        cyc();                                                   // E15: grant 0x10
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();                                                   // E16
        redirect_valid = 1'b0;
        chk("wait_rd_valid", {31'b0, instr_valid}, 32'd0);
        chk("wait_rd_req", {31'b0, imem_req}, 32'd0);
        cyc();                                                   // E17: stale rvalid visible
        chk("stale_rvalid", {31'b0, imem_rvalid}, 32'd1);
        cyc();                                                   // E18
        chk("drop_valid", {31'b0, instr_valid}, 32'd0);
        chk("drop_req", {31'b0, imem_req}, 32'd1);
        chk("drop_addr", imem_addr, 32'h100);
        mem_lat = 1;
        cyc();                                                   // E19
        cyc();                                                   // E20
        chk("new_valid", {31'b0, instr_valid}, 32'd1);
        chk("new_pc", instr_pc, 32'h100);
        chk("new_instr", instr, word_of(32'h100));

        // Ungranted request withdrawn; redirect beats instr_ready
        mem_auto       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        cyc();                                                   // E21
        chk("wd_valid", {31'b0, instr_valid}, 32'd0);
        chk("wd_instr", instr, NOP);
        chk("wd_addr", imem_addr, 32'h8);
        chk("wd_req", {31'b0, imem_req}, 32'd1);

        // Redirect coinciding with grant at addr 8
        mem_auto       = 1'b1;
        redirect_pc    = 32'h200;
        cyc();                                                   // E22
        redirect_valid = 1'b0;
        cyc();                                                   // E23
        chk("gr_valid", {31'b0, instr_valid}, 32'd0);
        chk("gr_addr", imem_addr, 32'h200);
        cyc();                                                   // E24
        cyc();                                                   // E25
        chk("gr_pc", instr_pc, 32'h200);
        chk("gr_instr", instr, word_of(32'h200));

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();                                                   // E26
        redirect_valid = 1'b0;
        cyc();                                                   // E27
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_valid0", {31'b0, instr_valid}, 32'd0);
        cyc();                                                   // E28
        cyc();                                                   // E29
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_next", imem_addr, 32'h0);
        cyc();                                                   // E30
        cyc();                                                   // E31
        chk("wrap_pc0", instr_pc, 32'h0);
        chk("wrap_valid", {31'b0, instr_valid}, 32'd1);

        // Misaligned redirect target
        mem_auto       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        cyc();                                                   // E32
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_flag", {31'b0, fetch_misaligned}, 32'd1);
        chk("mis_req", {31'b0, imem_req}, 32'd0);
        chk("mis_valid", {31'b0, instr_valid}, 32'd0);
        mem_auto    = 1'b1;
        redirect_pc = 32'h40;
        cyc();                                                   // E33
        redirect_valid = 1'b0;
        chk("clr_flag", {31'b0, fetch_misaligned}, 32'd0);
        chk("clr_req", {31'b0, imem_req}, 32'd1);
        chk("clr_addr", imem_addr, 32'h40);
        cyc();                                                   // E34
        cyc();                                                   // E35
        chk("clr_pc", instr_pc, 32'h40);
        mem_lat = 3;
        cyc();                                                   // E36: grant 0x44
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        cyc();                                                   // E37
        redirect_valid = 1'b0;
        chk("fw_flag", {31'b0, fetch_misaligned}, 32'd1);
        chk("fw_req", {31'b0, imem_req}, 32'd0);
        reset = 1'b1;
        cyc();                                                   // E38
        reset   = 1'b0;
        mem_lat = 1;
        chk("frst_flag", {31'b0, fetch_misaligned}, 32'd0);
        chk("frst_addr", imem_addr, 32'h0);
        chk("frst_valid", {31'b0, instr_valid}, 32'd0);
        cyc();                                                   // E39: stale rvalid ignored
        chk("frst_req", {31'b0, imem_req}, 32'd1);
        chk("frst_valid2", {31'b0, instr_valid}, 32'd0);
        cyc();                                                   // E40
        cyc();                                                   // E41
        chk("frst_pc", instr_pc, 32'h0);
        chk("frst_instr", instr, word_of(32'h0));
`else
        redirect_valid = 1'b0;
        chk("mask_addr", imem_addr, 32'h100);
        chk("mask_req", {31'b0, imem_req}, 32'd1);
        chk("mask_flag", {31'b0, fetch_misaligned}, 32'd0);
        mem_auto = 1'b1;
        mem_lat  = 3;
        cyc();                                                   // E33: grant 0x100
        reset = 1'b1;
        cyc();                                                   // E34
        reset = 1'b0;
        chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_req", {31'b0, imem_req}, 32'd0);
        cyc();                                                   // E35: stale rvalid present
        mem_lat = 1;
        chk("mrst_rvalid", {31'b0, imem_rvalid}, 32'd1);
        chk("mrst_addr2", imem_addr, 32'h0);
        cyc();                                                   // E36
        chk("mrst_valid2", {31'b0, instr_valid}, 32'd0);
        cyc();                                                   // E37
        chk("mrst_pc", instr_pc, 32'h0);
        chk("mrst_instr", instr, word_of(32'h0));
        chk("mrst_valid3", {31'b0, instr_valid}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
